calc_entry_fsm: RTL and testbench



---
 rtl/calc_pkg.sv | 43 ++++
 rtl/calc_entry_fsm_if.sv | 24 ++
 rtl/calc_alu.sv | 39 +++
 rtl/calc_entry_fsm.sv | 126 ++++++++++++
 tb/tb_calc_entry_fsm.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared key codes, operator and state types for the calculator entry path
package calc_pkg;

    localparam logic [4:0] KEY_ADD = 5'h10;
    localparam logic [4:0] KEY_MUL = 5'h11;
    localparam logic [4:0] KEY_AND = 5'h12;
    localparam logic [4:0] KEY_EXE = 5'h13;
    localparam logic [4:0] KEY_SUB = 5'h14;
    localparam logic [4:0] KEY_OR  = 5'h15;
    localparam logic [4:0] KEY_CE  = 5'h16;
    localparam logic [4:0] KEY_CLR = 5'h17;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_AND = 3'd3,
        OP_OR  = 3'd4
    } op_t;

    typedef enum logic [1:0] {
        S_OPA    = 2'd0,
        S_OPB    = 2'd1,
        S_EXEC   = 2'd2,
        S_RESULT = 2'd3
    } state_t;

    function automatic logic is_op_key(input logic [4:0] k);
        return (k == KEY_ADD) || (k == KEY_MUL) || (k == KEY_AND) ||
               (k == KEY_SUB) || (k == KEY_OR);
    endfunction

    function automatic op_t key_to_op(input logic [4:0] k);
        case (k)
            KEY_SUB: return OP_SUB;
            KEY_MUL: return OP_MUL;
            KEY_AND: return OP_AND;
            KEY_OR:  return OP_OR;
            default: return OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/calc_entry_fsm_if.sv
// rtl/calc_entry_fsm_if.sv - key strobe in, display/status out between keypad and entry FSM
interface calc_entry_fsm_if #(
    parameter int WIDTH = 16
);
    logic             key_valid;
    logic [4:0]       key_val;
    logic             dec_mode;
    logic             key_ready;
    logic [WIDTH-1:0] display_val;
    logic [2:0]       op_out;
    logic             in_operand_b;
    logic             overflow;
    logic             result_valid;

    modport master (
        output key_valid, key_val, dec_mode,
        input  key_ready, display_val, op_out, in_operand_b, overflow, result_valid
    );

    modport slave (
        input  key_valid, key_val, dec_mode,
        output key_ready, display_val, op_out, in_operand_b, overflow, result_valid
    );
endinterface

// File: rtl/calc_alu.sv
// rtl/calc_alu.sv - combinational operand ALU with per-operator overflow flag
module calc_alu
    import calc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_t              op,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        sum    = {1'b0, a} + {1'b0, b};
        prod   = (2*WIDTH)'(a) * (2*WIDTH)'(b);
        result = '0;
        ovf    = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum[WIDTH-1:0];
                ovf    = sum[WIDTH];
            end
            OP_SUB: begin
                result = a - b;
                ovf    = (a < b);
            end
            OP_MUL: begin
                result = prod[WIDTH-1:0];
                ovf    = |prod[2*WIDTH-1:WIDTH];
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            default: result = '0;
        endcase
    end
endmodule

// File: rtl/calc_entry_fsm.sv
// rtl/calc_entry_fsm.sv - assembles A op B from key strobes, executes, chains results
module calc_entry_fsm
    import calc_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int WIDTH  = 4*DIGITS
) (
    input  logic             clk,
    input  logic             rst,
    calc_entry_fsm_if.slave  bus
);
    localparam int CW = $clog2(DIGITS + 1);

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, disp_q, disp_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d, rv_q, rv_d;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic             digit_ok;

    calc_alu #(.WIDTH(WIDTH)) u_alu (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (alu_res),
        .ovf    (alu_ovf)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        rv_d     = 1'b0;
        digit_ok = !bus.key_val[4] && !(bus.dec_mode && (bus.key_val[3:0] > 4'd9));

        if (state_q == S_EXEC) begin
            a_d     = alu_res;
            ovf_d   = alu_ovf;
            rv_d    = 1'b1;
            state_d = S_RESULT;
        end else if (bus.key_valid) begin
            if (bus.key_val == KEY_CLR) begin
                state_d = S_OPA;
                op_d    = OP_ADD;
                a_d     = '0;
                b_d     = '0;
                cnt_d   = '0;
                ovf_d   = 1'b0;
            end else if (digit_ok) begin
                if (state_q == S_RESULT) begin
                    a_d     = WIDTH'(bus.key_val[3:0]);
                    cnt_d   = CW'(1);
                    ovf_d   = 1'b0;
                    state_d = S_OPA;
                end else if (cnt_q < CW'(DIGITS)) begin
                    cnt_d = cnt_q + CW'(1);
                    if (state_q == S_OPA) a_d = {a_q[WIDTH-5:0], bus.key_val[3:0]};
                    else                  b_d = {b_q[WIDTH-5:0], bus.key_val[3:0]};
                end
            end else if (is_op_key(bus.key_val)) begin
                case (state_q)
                    S_OPA, S_RESULT: begin
                        op_d    = key_to_op(bus.key_val);
                        b_d     = '0;
                        cnt_d   = '0;
                        state_d = S_OPB;
                        if (state_q == S_RESULT) ovf_d = 1'b0;
                    end
                    S_OPB: if (cnt_q == '0) op_d = key_to_op(bus.key_val);
                    default: ;
                endcase
            end else if (bus.key_val == KEY_EXE) begin
                if (state_q == S_OPB) state_d = S_EXEC;
            end else if (bus.key_val == KEY_CE) begin
                cnt_d = '0;
                case (state_q)
                    S_OPB: b_d = '0;
                    S_RESULT: begin
                        a_d     = '0;
                        ovf_d   = 1'b0;
                        state_d = S_OPA;
                    end
                    default: a_d = '0;
                endcase
            end
        end

        // Display is computed from next-state values so it lands with the key's effect.
        if (state_d == S_OPB && cnt_d != '0) disp_d = b_d;
        else                                 disp_d = a_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_OPA;
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            rv_q    <= 1'b0;
            disp_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            rv_q    <= rv_d;
            disp_q  <= disp_d;
        end
    end

    assign bus.key_ready    = (state_q != S_EXEC);
    assign bus.display_val  = disp_q;
    assign bus.op_out       = op_q;
    assign bus.in_operand_b = (state_q == S_OPB);
    assign bus.overflow     = ovf_q;
    assign bus.result_valid = rv_q;
endmodule

// File: tb/tb_calc_entry_fsm.sv
// tb/tb_calc_entry_fsm.sv - vector table, corner sequences and randomized model check of calc_entry_fsm
module tb_calc_entry_fsm;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    calc_entry_fsm_if #(.WIDTH(16)) bus ();
    calc_entry_fsm #(.DIGITS(4), .WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [4:0]  key;
        logic        dec;
        logic [15:0] disp;
        logic        ovf;
        logic [2:0]  op;
        logic        inb;
        logic        rv;
    } vec_t;

    vec_t vecs[$];

    // Reference model state: phase 0=entering A, 1=entering B, 2=showing result
    int m_phase, m_a, m_b, m_op, m_cnt, m_ovf, m_rv;

    function automatic vec_t mk(input logic [4:0] k, input logic d, input logic [15:0] disp,
                                input logic o, input logic [2:0] op, input logic inb, input logic rv);
        vec_t v;
        v.key = k; v.dec = d; v.disp = disp; v.ovf = o; v.op = op; v.inb = inb; v.rv = rv;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_key(input logic [4:0] k, input logic d);
        int waited;
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_val   = k;
        bus.dec_mode  = d;
        @(posedge clk);
        @(negedge clk);
        bus.key_valid = 1'b0;
        waited = 0;
        while (!bus.key_ready && waited < 4) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.key_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL exec_timeout: key_ready stuck low, required 1");
        end
    endtask

    function automatic int key2op(input int k);
        case (k)
            'h14: return 1;
            'h11: return 2;
            'h12: return 3;
            'h15: return 4;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = 0; m_a = 0; m_b = 0; m_op = 0; m_cnt = 0; m_ovf = 0; m_rv = 0;
    endtask

    task automatic model_key(input int k, input int d);
        longint p;
        m_rv = 0;
        if (k >= 'h18) return;
        if (k < 16) begin
            if (d != 0 && k > 9) return;
            if (m_phase == 2) begin
                m_a = k; m_cnt = 1; m_ovf = 0; m_phase = 0;
            end else if (m_cnt < 4) begin
                if (m_phase == 0) m_a = (m_a * 16 + k) % 65536;
                else              m_b = (m_b * 16 + k) % 65536;
                m_cnt++;
            end
        end else if (k == 'h10 || k == 'h11 || k == 'h12 || k == 'h14 || k == 'h15) begin
            if (m_phase == 1) begin
                if (m_cnt == 0) m_op = key2op(k);
            end else begin
                if (m_phase == 2) m_ovf = 0;
                m_op = key2op(k); m_b = 0; m_cnt = 0; m_phase = 1;
            end
        end else if (k == 'h13) begin
            if (m_phase == 1) begin
                case (m_op)
                    0: begin m_ovf = (m_a + m_b > 65535); m_a = (m_a + m_b) % 65536; end
                    1: begin m_ovf = (m_a < m_b); m_a = (m_a - m_b + 65536) % 65536; end
                    2: begin p = longint'(m_a) * longint'(m_b); m_ovf = (p > 65535); m_a = int'(p % 65536); end
                    3: begin m_a = m_a & m_b; m_ovf = 0; end
                    default: begin m_a = m_a | m_b; m_ovf = 0; end
                endcase
                m_phase = 2;
                m_rv = 1;
            end
        end else if (k == 'h16) begin
            if (m_phase == 1) m_b = 0;
            else begin m_a = 0; m_ovf = 0; m_phase = 0; end
            m_cnt = 0;
        end else begin
            model_reset();
        end
    endtask

    function automatic int model_disp();
        if (m_phase == 1 && m_cnt != 0) return m_b;
        return m_a;
    endfunction

    initial begin
        bus.key_valid = 1'b0;
        bus.key_val   = 5'h00;
        bus.dec_mode  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_display", bus.display_val, 16'h0);
        check("rst_key_ready", bus.key_ready, 1);
        check("rst_op", bus.op_out, 0);
        check("rst_ovf", bus.overflow, 0);
        check("rst_rv", bus.result_valid, 0);
        check("rst_inb", bus.in_operand_b, 0);

        // 1,2 ADD 3,4 EXE
        vecs.push_back(mk(5'h01, 0, 16'h0001, 0, 0, 0, 0));
        vecs.push_back(mk(5'h02, 0, 16'h0012, 0, 0, 0, 0));
        vecs.push_back(mk(5'h10, 0, 16'h0012, 0, 0, 1, 0));
        vecs.push_back(mk(5'h03, 0, 16'h0003, 0, 0, 1, 0));
        vecs.push_back(mk(5'h04, 0, 16'h0034, 0, 0, 1, 0));
        vecs.push_back(mk(5'h13, 0, 16'h0046, 0, 0, 0, 1));
        // FFFF (fifth F ignored) ADD 1 EXE
        vecs.push_back(mk(5'h0F, 0, 16'h000F, 0, 0, 0, 0));
        vecs.push_back(mk(5'h0F, 0, 16'h00FF, 0, 0, 0, 0));
        vecs.push_back(mk(5'h0F, 0, 16'h0FFF, 0, 0, 0, 0));
        vecs.push_back(mk(5'h0F, 0, 16'hFFFF, 0, 0, 0, 0));
        vecs.push_back(mk(5'h0F, 0, 16'hFFFF, 0, 0, 0, 0));
        vecs.push_back(mk(5'h10, 0, 16'hFFFF, 0, 0, 1, 0));
        vecs.push_back(mk(5'h01, 0, 16'h0001, 0, 0, 1, 0));
        vecs.push_back(mk(5'h13, 0, 16'h0000, 1, 0, 0, 1));
        // 3 SUB 5 EXE, chained MUL 2 EXE, then digit 7
        vecs.push_back(mk(5'h03, 0, 16'h0003, 0, 0, 0, 0));
        vecs.push_back(mk(5'h14, 0, 16'h0003, 0, 1, 1, 0));
        vecs.push_back(mk(5'h05, 0, 16'h0005, 0, 1, 1, 0));
        vecs.push_back(mk(5'h13, 0, 16'hFFFE, 1, 1, 0, 1));
        vecs.push_back(mk(5'h11, 0, 16'hFFFE, 0, 2, 1, 0));
        vecs.push_back(mk(5'h02, 0, 16'h0002, 0, 2, 1, 0));
        vecs.push_back(mk(5'h13, 0, 16'hFFFC, 1, 2, 0, 1));
        vecs.push_back(mk(5'h07, 0, 16'h0007, 0, 2, 0, 0));
        // CLR, 1,2 ADD, op replace, CE, 5, op ignored, EXE, CLR
        vecs.push_back(mk(5'h17, 0, 16'h0000, 0, 0, 0, 0));
        vecs.push_back(mk(5'h01, 0, 16'h0001, 0, 0, 0, 0));
        vecs.push_back(mk(5'h02, 0, 16'h0012, 0, 0, 0, 0));
        vecs.push_back(mk(5'h10, 0, 16'h0012, 0, 0, 1, 0));
        vecs.push_back(mk(5'h15, 0, 16'h0012, 0, 4, 1, 0));
        vecs.push_back(mk(5'h10, 0, 16'h0012, 0, 0, 1, 0));
        vecs.push_back(mk(5'h16, 0, 16'h0012, 0, 0, 1, 0));
        vecs.push_back(mk(5'h05, 0, 16'h0005, 0, 0, 1, 0));
        vecs.push_back(mk(5'h11, 0, 16'h0005, 0, 0, 1, 0));
        vecs.push_back(mk(5'h13, 0, 16'h0017, 0, 0, 0, 1));
        vecs.push_back(mk(5'h17, 0, 16'h0000, 0, 0, 0, 0));
        // decimal mode: A rejected, 9 taken, 0x1F and EXE ignored in S_OPA
        vecs.push_back(mk(5'h0A, 1, 16'h0000, 0, 0, 0, 0));
        vecs.push_back(mk(5'h09, 1, 16'h0009, 0, 0, 0, 0));
        vecs.push_back(mk(5'h1F, 1, 16'h0009, 0, 0, 0, 0));
        vecs.push_back(mk(5'h13, 1, 16'h0009, 0, 0, 0, 0));
        vecs.push_back(mk(5'h0A, 0, 16'h009A, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply_key(vecs[i].key, vecs[i].dec);
            check($sformatf("vec%0d_display", i), bus.display_val, vecs[i].disp);
            check($sformatf("vec%0d_ovf", i), bus.overflow, vecs[i].ovf);
            check($sformatf("vec%0d_op", i), bus.op_out, vecs[i].op);
            check($sformatf("vec%0d_inb", i), bus.in_operand_b, vecs[i].inb);
            check($sformatf("vec%0d_rv", i), bus.result_valid, vecs[i].rv);
        end
        @(negedge clk);
        check("rv_single_pulse", bus.result_valid, 0);

        // Strobe held during S_EXEC is dropped
        apply_key(5'h17, 0); apply_key(5'h01, 0); apply_key(5'h10, 0); apply_key(5'h02, 0);
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_val   = 5'h13;
        @(posedge clk);
        @(negedge clk);
        check("exec_key_ready", bus.key_ready, 0);
        bus.key_val = 5'h07;
        @(posedge clk);
        @(negedge clk);
        bus.key_valid = 1'b0;
        check("drop_display", bus.display_val, 16'h0003);
        check("drop_rv", bus.result_valid, 1);
        check("drop_inb", bus.in_operand_b, 0);
        @(negedge clk);
        check("drop_display_after", bus.display_val, 16'h0003);
        check("drop_rv_after", bus.result_valid, 0);

        // Reset during S_EXEC
        apply_key(5'h17, 0); apply_key(5'h0F, 0); apply_key(5'h11, 0); apply_key(5'h0F, 0);
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_val   = 5'h13;
        @(posedge clk);
        @(negedge clk);
        bus.key_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("exec_rst_display", bus.display_val, 16'h0);
        check("exec_rst_rv", bus.result_valid, 0);
        check("exec_rst_ready", bus.key_ready, 1);
        check("exec_rst_op", bus.op_out, 0);
        check("exec_rst_inb", bus.in_operand_b, 0);
        @(negedge clk);
        check("exec_rst_rv_after", bus.result_valid, 0);

        // Randomized keys against the reference model
        apply_key(5'h17, 0);
        model_reset();
        for (int i = 0; i < 400; i++) begin
            int k, d;
            k = int'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) k = 'h13;
            d = ($urandom_range(0, 3) == 0) ? 1 : 0;
            apply_key(5'(k), 1'(d));
            model_key(k, d);
            check($sformatf("rnd%0d_display", i), bus.display_val, 32'(model_disp()));
            check($sformatf("rnd%0d_ovf", i), bus.overflow, 32'(m_ovf));
            check($sformatf("rnd%0d_op", i), bus.op_out, 32'(m_op));
            check($sformatf("rnd%0d_inb", i), bus.in_operand_b, (m_phase == 1) ? 1 : 0);
            check($sformatf("rnd%0d_rv", i), bus.result_valid, 32'(m_rv));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
